seg_scan_driver: RTL

- Consumes the 32-bit packed-nibble display bus produced by puzzle blocks and drives an 8-digit multiplexed 7-segment display.
- Nibble 7, bits [31:28], is the leftmost digit; nibble 0, bits [3:0], is the rightmost.
- Nibble value 0xF means blank.
- Latches the bus once per scan frame so the panel never tears, and time-multiplexes one digit at a time with registered outputs.

---
 rtl/seg_scan_driver.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// 8-digit multiplexed 7-segment scan driver; latches the packed-nibble bus once per frame.
// Optional macro SEG_DEADTIME_EN blanks the first DEAD_CYCLES cycles of every digit slot.
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned DIG_ACTIVE_LOW = 1,
    parameter int unsigned DEAD_CYCLES    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] seg_display,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  seg_out,
    output logic [7:0]  dig_sel,
    output logic        frame_start
);

    localparam int unsigned    CNT_W   = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [7:0]     SEG_POL = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [7:0]     DIG_POL = (DIG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    // WAIT: no frame latched since reset; SCAN: panel is being refreshed
    localparam logic [0:0] ST_WAIT = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    if (SCAN_DIV < 2 || SCAN_DIV > 65535) begin : g_bad_div
        $error("seg_scan_driver: SCAN_DIV must be in 2..65535");
    end
    if (DEAD_CYCLES >= SCAN_DIV) begin : g_bad_dead
        $error("seg_scan_driver: DEAD_CYCLES must be less than SCAN_DIV");
    end

    logic [0:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [31:0]      lat_data, data_nxt;
    logic [7:0]       lat_dp, dp_nxt;
    logic             slot_tick_c;
    logic             load_c;
    logic             show_c;
    logic [3:0]       nib_c;
    logic [7:0]       seg_hi_c;
    logic [7:0]       seg_nxt, dig_nxt;

    function automatic logic [6:0] decode7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Next-state, frame latch control and next output values
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load_c    = 1'b0;

        slot_tick_c = (cnt == CNT_MAX);
        cnt_nxt     = slot_tick_c ? '0 : cnt + CNT_W'(1);

        case (state)
            ST_WAIT: begin
                if (slot_tick_c) begin
                    load_c    = 1'b1;
                    idx_nxt   = 3'd0;
                    state_nxt = ST_SCAN;
                end
            end
            default: begin
                if (slot_tick_c) begin
                    idx_nxt = idx + 3'd1;
                    load_c  = (idx == 3'd7);
                end
            end
        endcase

        // Outputs are computed from post-latch values so they update with the latch itself
        data_nxt = load_c ? seg_display : lat_data;
        dp_nxt   = load_c ? dp_mask : lat_dp;
        nib_c    = data_nxt[{idx_nxt, 2'b00} +: 4];
        seg_hi_c = {dp_nxt[idx_nxt], decode7(nib_c)};

`ifdef SEG_DEADTIME_EN
        show_c = (state_nxt == ST_SCAN) && (cnt_nxt >= CNT_W'(DEAD_CYCLES));
`else
        show_c = (state_nxt == ST_SCAN);
`endif

        seg_nxt = (show_c ? seg_hi_c : 8'h00) ^ SEG_POL;
        dig_nxt = (show_c ? (8'h01 << idx_nxt) : 8'h00) ^ DIG_POL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_WAIT;
            cnt         <= '0;
            idx         <= 3'd0;
            lat_data    <= 32'hFFFF_FFFF;
            lat_dp      <= 8'h00;
            seg_out     <= SEG_POL;
            dig_sel     <= DIG_POL;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            lat_data    <= data_nxt;
            lat_dp      <= dp_nxt;
            seg_out     <= seg_nxt;
            dig_sel     <= dig_nxt;
            frame_start <= load_c;
        end
    end

endmodule
